// File: rtl/mac_send.sv
// Ethernet MAC framer: preamble/SFD/MAC header, zero padding to 60 bytes,
// CRC-32 FCS and a 12-byte inter-frame gap on a byte-wide PHY interface.
//
// state | meaning
// IDLE  | waiting for a frame start; ready=1
// SHIFT | streaming header and payload through the 20-byte shift register
// PAD   | zero bytes until 60 post-SFD bytes have been sent
// FCS   | four bytes of inverted CRC, low byte first
// IFG   | tx_en low for 12 cycles
module mac_send (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  input  logic [47:0] local_mac,
  input  logic [47:0] destination_mac,
  output logic        ready,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, SHIFT, PAD, FCS, IFG} state_t;

  localparam logic [10:0] MIN_BODY = 11'd60;

  state_t       state, state_nxt;
  logic [159:0] sr, sr_nxt;
  logic [151:0] hdr_tail;
  logic [31:0]  crc, crc_nxt, crc_inv;
  logic [10:0]  byte_cnt, byte_cnt_nxt, byte_inc;
  logic [3:0]   pre_cnt, pre_cnt_nxt;
  logic [4:0]   purge_cnt, purge_cnt_nxt;
  logic [3:0]   gap_cnt, gap_cnt_nxt;
  logic         in_burst, in_burst_nxt;
  logic         ignore, ignore_nxt;
  logic         dv_q, dv_rise, take_byte;
  logic         tx_en_nxt, overrun_nxt;
  logic [7:0]   tx_data_nxt;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // First preamble byte goes straight to tx_data on the start edge, so only
  // the remaining 19 header bytes are loaded ahead of the first payload byte.
  assign hdr_tail  = {48'h555555555555, 8'hD5, destination_mac, local_mac};
  assign ready     = (state == IDLE);
  assign dv_rise   = data_valid && !dv_q;
  assign take_byte = in_burst && data_valid;
  assign byte_inc  = (byte_cnt == 11'd2047) ? byte_cnt : byte_cnt + 11'd1;
  assign crc_inv   = ~crc;

  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    crc_nxt       = crc;
    byte_cnt_nxt  = byte_cnt;
    pre_cnt_nxt   = pre_cnt;
    purge_cnt_nxt = purge_cnt;
    gap_cnt_nxt   = gap_cnt;
    in_burst_nxt  = in_burst;
    tx_en_nxt     = 1'b0;
    tx_data_nxt   = 8'h00;
    overrun_nxt   = dv_rise && (state != IDLE);
    // A burst that began while busy stays ignored until data_valid drops.
    ignore_nxt    = data_valid && (ignore || overrun_nxt);

    case (state)
      IDLE: begin
        if (data_valid && !ignore) begin
          state_nxt     = SHIFT;
          tx_en_nxt     = 1'b1;
          tx_data_nxt   = 8'h55;
          sr_nxt        = {hdr_tail, data_in};
          crc_nxt       = 32'hFFFFFFFF;
          byte_cnt_nxt  = 11'd0;
          pre_cnt_nxt   = 4'd1;
          purge_cnt_nxt = 5'd20;
          in_burst_nxt  = 1'b1;
        end
      end
      SHIFT: begin
        tx_en_nxt   = 1'b1;
        tx_data_nxt = sr[159:152];
        if (pre_cnt == 4'd8) begin
          crc_nxt      = crc_byte(crc, sr[159:152]);
          byte_cnt_nxt = byte_inc;
        end else begin
          pre_cnt_nxt = pre_cnt + 4'd1;
        end
        if (take_byte) begin
          sr_nxt = {sr[151:0], data_in};
        end else begin
          sr_nxt        = {sr[151:0], 8'h00};
          in_burst_nxt  = 1'b0;
          purge_cnt_nxt = purge_cnt - 5'd1;
          if (purge_cnt == 5'd1) begin
            state_nxt   = (byte_inc < MIN_BODY) ? PAD : FCS;
            gap_cnt_nxt = 4'd0;
          end
        end
      end
      PAD: begin
        tx_en_nxt    = 1'b1;
        crc_nxt      = crc_byte(crc, 8'h00);
        byte_cnt_nxt = byte_inc;
        if (byte_inc == MIN_BODY) begin
          state_nxt   = FCS;
          gap_cnt_nxt = 4'd0;
        end
      end
      FCS: begin
        tx_en_nxt = 1'b1;
        case (gap_cnt[1:0])
          2'd0:    tx_data_nxt = crc_inv[7:0];
          2'd1:    tx_data_nxt = crc_inv[15:8];
          2'd2:    tx_data_nxt = crc_inv[23:16];
          default: tx_data_nxt = crc_inv[31:24];
        endcase
        gap_cnt_nxt = gap_cnt + 4'd1;
        if (gap_cnt == 4'd3) begin
          state_nxt   = IFG;
          gap_cnt_nxt = 4'd11;
        end
      end
      IFG: begin
        if (gap_cnt == 4'd0) state_nxt = IDLE;
        else                 gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      sr        <= '0;
      crc       <= 32'hFFFFFFFF;
      byte_cnt  <= 11'd0;
      pre_cnt   <= 4'd0;
      purge_cnt <= 5'd0;
      gap_cnt   <= 4'd0;
      in_burst  <= 1'b0;
      ignore    <= 1'b0;
      dv_q      <= 1'b0;
      tx_en     <= 1'b0;
      tx_data   <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      crc       <= crc_nxt;
      byte_cnt  <= byte_cnt_nxt;
      pre_cnt   <= pre_cnt_nxt;
      purge_cnt <= purge_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      in_burst  <= in_burst_nxt;
      ignore    <= ignore_nxt;
      dv_q      <= data_valid;
      tx_en     <= tx_en_nxt;
      tx_data   <= tx_data_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule
